// File: rtl/fbf_pkg.sv
// Shared constants, FSM state encoding and row-major operand packing helper
// for the fbf word-serial front/back end.
package fbf_pkg;

  localparam int MAT_DIM   = 4;
  localparam int WORD_W    = 32;
  localparam int MAT_WORDS = MAT_DIM * MAT_DIM;
  localparam int MAT_W     = MAT_WORDS * WORD_W;

  typedef enum logic [2:0] {
    S_LOAD,
    S_STROBE,
    S_WAIT,
    S_ACK,
    S_DRAIN
  } state_t;

  // Bit offset of element (m,n) in a packed row-major matrix: (4m+n)*32.
  function automatic logic [8:0] elem_off(input logic [1:0] m, input logic [1:0] n);
    return 9'((int'(m) * MAT_DIM + int'(n)) * WORD_W);
  endfunction

endpackage

// File: rtl/fbf_word_serializer.sv
// Result buffer plus valid/ready word serializer: emits the 16 buffered
// result words in row-major order, flagging the last one.
module fbf_word_serializer
  import fbf_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_en,
  input  logic [MAT_W-1:0]  cap_data,
  input  logic              start,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              done
);

  logic [MAT_W-1:0] res_buf_q, res_buf_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             valid_q, valid_d;

  always_comb begin
    res_buf_d = cap_en ? cap_data : res_buf_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    done      = 1'b0;
    if (start) begin
      valid_d = 1'b1;
      cnt_d   = '0;
    end else if (valid_q && out_ready) begin
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'(MAT_WORDS - 1)) begin
        valid_d = 1'b0;
        done    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_buf_q <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      res_buf_q <= res_buf_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
    end
  end

  // The word index only moves on a handshake, so out_data is stable under backpressure.
  assign out_valid = valid_q;
  assign out_data  = res_buf_q[elem_off(cnt_q[3:2], cnt_q[1:0]) +: WORD_W];
  assign out_last  = valid_q && (cnt_q == 4'(MAT_WORDS - 1));

endmodule

// File: rtl/fbf_stream_io.sv
// Word-serial front/back end for the 4x4 matrix multiplier: loads A then B,
// strobes the multiplier, captures/acks its result and streams it out.
// Optional S_WAIT abort with sticky err: define FBF_STREAM_IO_TIMEOUT_EN.
module fbf_stream_io
  import fbf_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_CNT_W       = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic [MAT_W-1:0]  mat_a,
  output logic [MAT_W-1:0]  mat_b,
  output logic              a_stb,
  output logic              b_stb,
  input  logic [MAT_W-1:0]  mul_result,
  input  logic              mul_result_ready,
  output logic              mul_result_ack,
  output logic              err
);

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic [MAT_W-1:0] mat_a_q, mat_a_d, mat_b_q, mat_b_d;
  logic [MAT_W-1:0] cap_data;
  logic             cap_en, ser_start, ser_done, timeout;

`ifdef FBF_STREAM_IO_TIMEOUT_EN
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic                err_q, err_d;

  assign timeout = (state_q == S_WAIT) && !mul_result_ready &&
                   (to_cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter idles at zero outside S_WAIT, so every entry starts a fresh count.
  always_comb begin
    to_cnt_d = (state_q == S_WAIT) ? to_cnt_q + TO_CNT_W'(1) : '0;
    err_d    = err_q | timeout;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_to_cfg;
  assign unused_to_cfg = (TIMEOUT_CYCLES > 0) || (TO_CNT_W > 0);
  assign timeout       = 1'b0;
  assign err           = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mat_a_d   = mat_a_q;
    mat_b_d   = mat_b_q;
    cap_en    = 1'b0;
    cap_data  = mul_result;
    ser_start = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          if (cnt_q[4]) mat_b_d[elem_off(cnt_q[3:2], cnt_q[1:0]) +: WORD_W] = in_data;
          else          mat_a_d[elem_off(cnt_q[3:2], cnt_q[1:0]) +: WORD_W] = in_data;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_STROBE;
        end
      end
      S_STROBE: state_d = S_WAIT;
      S_WAIT: begin
        if (mul_result_ready) begin
          cap_en  = 1'b1;
          state_d = S_ACK;
        end else if (timeout) begin
          cap_en    = 1'b1;
          cap_data  = '0;
          ser_start = 1'b1;
          state_d   = S_DRAIN;
        end
      end
      S_ACK: begin
        if (!mul_result_ready) begin
          ser_start = 1'b1;
          state_d   = S_DRAIN;
        end
      end
      S_DRAIN:  if (ser_done) state_d = S_LOAD;
      default:  state_d = S_LOAD;
    endcase
    // Registered ready keeps it low through reset and for one cycle after release.
    in_ready_d = (state_d == S_LOAD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_LOAD;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      mat_a_q    <= '0;
      mat_b_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      mat_a_q    <= mat_a_d;
      mat_b_q    <= mat_b_d;
    end
  end

  fbf_word_serializer u_ser (
    .clk       (clk),
    .reset     (reset),
    .cap_en    (cap_en),
    .cap_data  (cap_data),
    .start     (ser_start),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (ser_done)
  );

  assign in_ready       = in_ready_q;
  assign mat_a          = mat_a_q;
  assign mat_b          = mat_b_q;
  assign a_stb          = (state_q == S_STROBE);
  assign b_stb          = (state_q == S_STROBE);
  assign mul_result_ack = (state_q == S_ACK);

endmodule
